// File: rtl/chan_pwr_integrator.sv
// Per-channel power integrator with ping-pong accumulator banks and a valid/ready dump port.
// Optional per-channel peak tracking is compiled in when CHAN_PWR_INTEGRATOR_PEAK_EN is defined.
module chan_pwr_integrator #(
  parameter int NUM_CHANNELS        = 32,
  parameter int CHANNEL_INDEX_WIDTH = $clog2(NUM_CHANNELS),
  parameter int POWER_WIDTH         = 32,
  parameter int INTEG_WIDTH         = 8,
  parameter int ACC_WIDTH           = POWER_WIDTH + INTEG_WIDTH
) (
  input  logic                           Clk,
  input  logic                           Rst_n,
  input  logic                           Input_valid,
  input  logic [CHANNEL_INDEX_WIDTH-1:0] Input_index,
  input  logic [POWER_WIDTH-1:0]         Input_pwr,
  input  logic [INTEG_WIDTH-1:0]         Integration_frames,
  output logic                           Output_valid,
  input  logic                           Output_ready,
  output logic [CHANNEL_INDEX_WIDTH-1:0] Output_index,
  output logic [ACC_WIDTH-1:0]           Output_data,
  output logic [POWER_WIDTH-1:0]         Output_peak,
  output logic                           Output_last,
  output logic                           Error_sequence,
  output logic                           Error_overflow,
  output logic                           Error_dump_overrun,
  output logic                           Dbg_in_state,
  output logic                           Dbg_dump_state
);

  typedef enum logic {IN_SYNC, IN_ACCUM} in_state_t;
  typedef enum logic {DUMP_IDLE, DUMP_ACTIVE} dump_state_t;

  localparam logic [CHANNEL_INDEX_WIDTH-1:0] LAST_IDX = CHANNEL_INDEX_WIDTH'(NUM_CHANNELS - 1);
  localparam logic [CHANNEL_INDEX_WIDTH-1:0] IDX_ONE  = 1;
  localparam logic [INTEG_WIDTH-1:0]         FRM_ONE  = 1;

  // Input side state
  in_state_t                      in_state, in_state_nxt;
  logic [CHANNEL_INDEX_WIDTH-1:0] exp_idx, exp_idx_nxt;
  logic [INTEG_WIDTH-1:0]         frame_cnt, frame_cnt_nxt;
  logic [INTEG_WIDTH-1:0]         frames_lat, frames_lat_nxt;
  logic [INTEG_WIDTH-1:0]         frames_in;
  logic                           fill_bank;
  logic                           accept, first, seq_err, complete;
  logic                           dump_busy, swap, overrun;

  // Read-modify-write stage
  logic                           s1_valid, s1_first, s1_bank, s1_swap;
  logic [CHANNEL_INDEX_WIDTH-1:0] s1_idx;
  logic [POWER_WIDTH-1:0]         s1_pwr;
  logic [ACC_WIDTH-1:0]           acc_mem [2][NUM_CHANNELS];
  logic [ACC_WIDTH-1:0]           acc_old, acc_new;
  logic [ACC_WIDTH:0]             acc_sum;
  logic                           acc_sat;

  // Dump side state
  dump_state_t                    dump_state, dump_state_nxt;
  logic [CHANNEL_INDEX_WIDTH-1:0] dump_idx, dump_idx_nxt;
  logic                           dump_bank, dump_bank_nxt;
  logic                           out_en;

  logic err_seq_q, err_ovf_q, err_ovr_q;

  assign frames_in = (Integration_frames == '0) ? FRM_ONE : Integration_frames;

  // A sample at index 0 opens a new integration unless it is the in-order
  // continuation of a later frame; out-of-order index 0 resyncs in place.
  always_comb begin
    in_state_nxt   = in_state;
    exp_idx_nxt    = exp_idx;
    frame_cnt_nxt  = frame_cnt;
    frames_lat_nxt = frames_lat;
    accept         = 1'b0;
    first          = 1'b0;
    seq_err        = 1'b0;
    complete       = 1'b0;
    if (Input_valid) begin
      if (in_state == IN_ACCUM && Input_index != exp_idx) begin
        seq_err = 1'b1;
      end
      if (in_state == IN_ACCUM && Input_index == exp_idx &&
          !(Input_index == '0 && frame_cnt == '0)) begin
        accept      = 1'b1;
        first       = (frame_cnt == '0);
        exp_idx_nxt = exp_idx + IDX_ONE;
        if (Input_index == LAST_IDX) begin
          if (frame_cnt == frames_lat - FRM_ONE) begin
            complete      = 1'b1;
            frame_cnt_nxt = '0;
          end else begin
            frame_cnt_nxt = frame_cnt + FRM_ONE;
          end
        end
      end else if (Input_index == '0) begin
        accept         = 1'b1;
        first          = 1'b1;
        in_state_nxt   = IN_ACCUM;
        exp_idx_nxt    = IDX_ONE;
        frame_cnt_nxt  = '0;
        frames_lat_nxt = frames_in;
      end else if (seq_err) begin
        in_state_nxt = IN_SYNC;
      end
    end
  end

  // A swap already in the pipeline counts as busy so two completions never
  // target the same dump.
  assign dump_busy = (dump_state == DUMP_ACTIVE) || (s1_valid && s1_swap);
  assign swap      = complete && !dump_busy;
  assign overrun   = complete && dump_busy;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      in_state   <= IN_SYNC;
      exp_idx    <= '0;
      frame_cnt  <= '0;
      frames_lat <= FRM_ONE;
      fill_bank  <= 1'b0;
      s1_valid   <= 1'b0;
      s1_first   <= 1'b0;
      s1_bank    <= 1'b0;
      s1_swap    <= 1'b0;
      s1_idx     <= '0;
      s1_pwr     <= '0;
      err_seq_q  <= 1'b0;
      err_ovf_q  <= 1'b0;
      err_ovr_q  <= 1'b0;
    end else begin
      in_state   <= in_state_nxt;
      exp_idx    <= exp_idx_nxt;
      frame_cnt  <= frame_cnt_nxt;
      frames_lat <= frames_lat_nxt;
      if (swap) begin
        fill_bank <= ~fill_bank;
      end
      s1_valid   <= accept;
      s1_first   <= first;
      s1_bank    <= fill_bank;
      s1_swap    <= swap;
      s1_idx     <= Input_index;
      s1_pwr     <= Input_pwr;
      err_seq_q  <= seq_err;
      err_ovf_q  <= s1_valid && acc_sat;
      err_ovr_q  <= overrun;
    end
  end

  // Consecutive samples always address different channels, so the read of
  // stage 1 never needs the write still in flight.
  always_comb begin
    acc_old = acc_mem[s1_bank][s1_idx];
    acc_sum = {1'b0, acc_old} + {{(ACC_WIDTH + 1 - POWER_WIDTH){1'b0}}, s1_pwr};
    acc_sat = !s1_first && acc_sum[ACC_WIDTH];
    if (s1_first) begin
      acc_new = ACC_WIDTH'(s1_pwr);
    end else if (acc_sum[ACC_WIDTH]) begin
      acc_new = '1;
    end else begin
      acc_new = acc_sum[ACC_WIDTH-1:0];
    end
  end

  always_ff @(posedge Clk) begin
    if (s1_valid) begin
      acc_mem[s1_bank][s1_idx] <= acc_new;
    end
  end

  // Dump handshake: a word moves on a Clk edge where Output_valid && Output_ready;
  // while Output_valid && !Output_ready, index/data/peak/last hold and valid stays high.
  always_comb begin
    dump_state_nxt = dump_state;
    dump_idx_nxt   = dump_idx;
    dump_bank_nxt  = dump_bank;
    case (dump_state)
      DUMP_IDLE: begin
        if (s1_valid && s1_swap) begin
          dump_state_nxt = DUMP_ACTIVE;
          dump_idx_nxt   = '0;
          dump_bank_nxt  = s1_bank;
        end
      end
      DUMP_ACTIVE: begin
        if (Output_ready) begin
          if (dump_idx == LAST_IDX) begin
            dump_state_nxt = DUMP_IDLE;
          end else begin
            dump_idx_nxt = dump_idx + IDX_ONE;
          end
        end
      end
      default: dump_state_nxt = DUMP_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      dump_state <= DUMP_IDLE;
      dump_idx   <= '0;
      dump_bank  <= 1'b0;
    end else begin
      dump_state <= dump_state_nxt;
      dump_idx   <= dump_idx_nxt;
      dump_bank  <= dump_bank_nxt;
    end
  end

  // Outputs are forced low whenever Rst_n is low so nothing leaks during reset.
  assign out_en             = Rst_n && (dump_state == DUMP_ACTIVE);
  assign Output_valid       = out_en;
  assign Output_index       = out_en ? dump_idx : '0;
  assign Output_data        = out_en ? acc_mem[dump_bank][dump_idx] : '0;
  assign Output_last        = out_en && (dump_idx == LAST_IDX);
  assign Error_sequence     = Rst_n && err_seq_q;
  assign Error_overflow     = Rst_n && err_ovf_q;
  assign Error_dump_overrun = Rst_n && err_ovr_q;
  assign Dbg_in_state       = in_state;
  assign Dbg_dump_state     = dump_state;

`ifdef CHAN_PWR_INTEGRATOR_PEAK_EN
  logic [POWER_WIDTH-1:0] peak_mem [2][NUM_CHANNELS];
  logic [POWER_WIDTH-1:0] peak_old, peak_new;

  always_comb begin
    peak_old = peak_mem[s1_bank][s1_idx];
    peak_new = (s1_first || s1_pwr > peak_old) ? s1_pwr : peak_old;
  end

  always_ff @(posedge Clk) begin
    if (s1_valid) begin
      peak_mem[s1_bank][s1_idx] <= peak_new;
    end
  end

  assign Output_peak = out_en ? peak_mem[dump_bank][dump_idx] : '0;
`else
  assign Output_peak = '0;
`endif

endmodule

// File: tb/tb_chan_pwr_integrator.sv
// Directed bench for chan_pwr_integrator: main instance with N=8 default widths,
// plus an 8-bit saturating instance for the overflow scenario.
module tb_chan_pwr_integrator;

`ifdef CHAN_PWR_INTEGRATOR_PEAK_EN
  localparam bit PEAK_ON = 1'b1;
`else
  localparam bit PEAK_ON = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        in_valid;
  logic [2:0]  in_index;
  logic [31:0] in_pwr;
  logic [7:0]  in_frames;
  logic        out_ready;
  logic        sel_sat;

  logic        m_valid, m_last, m_eseq, m_eovf, m_eovr, m_dbg_in, m_dbg_dump;
  logic [2:0]  m_index;
  logic [39:0] m_data;
  logic [31:0] m_peak;
  logic        s_valid, s_last, s_eseq, s_eovf, s_eovr, s_dbg_in, s_dbg_dump;
  logic [2:0]  s_index;
  logic [7:0]  s_data, s_peak;

  logic [2:0]  cap_idx_q[$];
  logic [39:0] cap_data_q[$];
  logic [31:0] cap_peak_q[$];
  logic        cap_last_q[$];
  logic [7:0]  s_data_q[$];
  logic [39:0] exp_q[$];
  logic [31:0] exp_peak_q[$];
  int n_seq, n_ovf, n_ovr;
  int checks = 0;
  int errors = 0;

  chan_pwr_integrator #(.NUM_CHANNELS(8)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Input_valid(in_valid && !sel_sat), .Input_index(in_index),
    .Input_pwr(in_pwr), .Integration_frames(in_frames), .Output_valid(m_valid),
    .Output_ready(out_ready), .Output_index(m_index), .Output_data(m_data),
    .Output_peak(m_peak), .Output_last(m_last), .Error_sequence(m_eseq),
    .Error_overflow(m_eovf), .Error_dump_overrun(m_eovr),
    .Dbg_in_state(m_dbg_in), .Dbg_dump_state(m_dbg_dump));

  chan_pwr_integrator #(.NUM_CHANNELS(8), .POWER_WIDTH(8), .ACC_WIDTH(8)) dut_sat (
    .Clk(Clk), .Rst_n(Rst_n), .Input_valid(in_valid && sel_sat), .Input_index(in_index),
    .Input_pwr(in_pwr[7:0]), .Integration_frames(in_frames), .Output_valid(s_valid),
    .Output_ready(out_ready), .Output_index(s_index), .Output_data(s_data),
    .Output_peak(s_peak), .Output_last(s_last), .Error_sequence(s_eseq),
    .Error_overflow(s_eovf), .Error_dump_overrun(s_eovr),
    .Dbg_in_state(s_dbg_in), .Dbg_dump_state(s_dbg_dump));

  // Clock and watchdog
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Monitor: transfers and error pulses sampled mid-cycle
  always @(negedge Clk) begin
    if (m_valid && out_ready) begin
      cap_idx_q.push_back(m_index);
      cap_data_q.push_back(m_data);
      cap_peak_q.push_back(m_peak);
      cap_last_q.push_back(m_last);
    end
    if (s_valid && out_ready) s_data_q.push_back(s_data);
    if (m_eseq) n_seq++;
    if (s_eovf) n_ovf++;
    if (m_eovr) n_ovr++;
  end

  // Driver tasks; all start and end at posedge+1
  task automatic idle(input int n);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  task automatic send_sample(input int idx, input logic [31:0] pwr, input int gap);
    in_valid = 1'b1;
    in_index = 3'(idx);
    in_pwr   = pwr;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    idle(gap);
  endtask

  task automatic clear_all();
    cap_idx_q.delete(); cap_data_q.delete(); cap_peak_q.delete(); cap_last_q.delete();
    s_data_q.delete(); exp_q.delete(); exp_peak_q.delete();
    n_seq = 0; n_ovf = 0; n_ovr = 0;
  endtask

  task automatic wait_words(input int n, input bit sat, input int budget, input string name);
    int k = 0;
    while ((sat ? s_data_q.size() : cap_data_q.size()) < n && k < budget) begin
      @(posedge Clk); #1;
      k++;
    end
    checks++;
    if ((sat ? s_data_q.size() : cap_data_q.size()) < n) begin
      errors++;
      $display("FAIL %s_timeout got=%0d words exp=%0d", name,
               sat ? s_data_q.size() : cap_data_q.size(), n);
    end
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; in_valid = 1'b0; in_index = '0; in_pwr = '0; in_frames = 8'd1;
    out_ready = 1'b0; sel_sat = 1'b0;
    clear_all();
    idle(3);
    @(negedge Clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0d exp=0", m_valid); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_last got=%0d exp=0", m_last); end
    checks++; if (m_index !== 3'd0) begin errors++; $display("FAIL reset_index got=%0d exp=0", m_index); end
    checks++; if (m_data !== 40'd0) begin errors++; $display("FAIL reset_data got=%0d exp=0", m_data); end
    checks++; if (m_peak !== 32'd0) begin errors++; $display("FAIL reset_peak got=%0d exp=0", m_peak); end
    checks++; if ({m_eseq, m_eovf, m_eovr} !== 3'b000) begin errors++; $display("FAIL reset_errors got=%b exp=000", {m_eseq, m_eovf, m_eovr}); end
    checks++; if ({m_dbg_in, m_dbg_dump} !== 2'b00) begin errors++; $display("FAIL reset_states got=%b exp=00", {m_dbg_in, m_dbg_dump}); end
    checks++;
    if ({s_valid, s_last, s_eseq, s_eovf, s_eovr, s_dbg_in, s_dbg_dump, |s_index, |s_data, |s_peak} !== 10'd0) begin
      errors++; $display("FAIL reset_sat_outputs got=%b exp=0",
        {s_valid, s_last, s_eseq, s_eovf, s_eovr, s_dbg_in, s_dbg_dump, |s_index, |s_data, |s_peak});
    end
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    int lat;
    clear_all();
    out_ready = 1'b1;
    in_frames = 8'd4;
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < 8; i++) send_sample(i, 32'd100, 0);
    lat = 0;
    while (!m_valid && lat < 6) begin @(negedge Clk); lat++; end
    checks++; if (lat > 3) begin errors++; $display("FAIL basic_latency got=%0d exp<=3", lat); end
    @(posedge Clk); #1;
    wait_words(8, 1'b0, 30, "basic");
    idle(4);
    checks++; if (cap_data_q.size() != 8) begin errors++; $display("FAIL basic_count got=%0d exp=8", cap_data_q.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (cap_idx_q[i] !== 3'(i)) begin errors++; $display("FAIL basic_index[%0d] got=%0d exp=%0d", i, cap_idx_q[i], i); end
      checks++; if (cap_data_q[i] !== 40'd400) begin errors++; $display("FAIL basic_data[%0d] got=%0d exp=400", i, cap_data_q[i]); end
      checks++; if (cap_last_q[i] !== (i == 7)) begin errors++; $display("FAIL basic_last[%0d] got=%0d exp=%0d", i, cap_last_q[i], i == 7); end
      checks++; if (cap_peak_q[i] !== (PEAK_ON ? 32'd100 : 32'd0)) begin errors++; $display("FAIL basic_peak[%0d] got=%0d", i, cap_peak_q[i]); end
    end
  endtask

  task automatic test_pattern();
    clear_all();
    out_ready = 1'b1;
    in_frames = 8'd2;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 8; i++) begin
        send_sample(i, (f == 0) ? 32'(i * 10) : 32'd5, i % 3);
        in_frames = 8'd7;
      end
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(40'(i * 10 + 5));
      exp_peak_q.push_back(PEAK_ON ? ((i * 10 > 5) ? 32'(i * 10) : 32'd5) : 32'd0);
    end
    wait_words(8, 1'b0, 30, "pattern");
    for (int i = 0; i < 8; i++) begin
      checks++; if (cap_data_q[i] !== exp_q[i]) begin errors++; $display("FAIL pattern_data[%0d] got=%0d exp=%0d", i, cap_data_q[i], exp_q[i]); end
      checks++; if (cap_peak_q[i] !== exp_peak_q[i]) begin errors++; $display("FAIL pattern_peak[%0d] got=%0d exp=%0d", i, cap_peak_q[i], exp_peak_q[i]); end
    end
    idle(4);
  endtask

  task automatic test_overflow();
    clear_all();
    sel_sat = 1'b1;
    out_ready = 1'b1;
    in_frames = 8'd2;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 8; i++) send_sample(i, 32'd200, 0);
    wait_words(8, 1'b1, 30, "overflow");
    idle(3);
    for (int i = 0; i < 8; i++) begin
      checks++; if (s_data_q[i] !== 8'd255) begin errors++; $display("FAIL overflow_data[%0d] got=%0d exp=255", i, s_data_q[i]); end
    end
    checks++; if (n_ovf != 8) begin errors++; $display("FAIL overflow_pulses got=%0d exp=8", n_ovf); end
    checks++; if (cap_data_q.size() != 0) begin errors++; $display("FAIL overflow_main_quiet got=%0d exp=0", cap_data_q.size()); end
    sel_sat = 1'b0;
  endtask

  task automatic test_sequence();
    int idxs[4] = '{0, 1, 2, 5};
    clear_all();
    out_ready = 1'b1;
    in_frames = 8'd1;
    for (int k = 0; k < 4; k++) send_sample(idxs[k], 32'd1, 0);
    idle(2);
    checks++; if (n_seq != 1) begin errors++; $display("FAIL seq_pulse got=%0d exp=1", n_seq); end
    checks++; if (m_dbg_in !== 1'b0) begin errors++; $display("FAIL seq_sync_state got=%0d exp=0", m_dbg_in); end
    send_sample(6, 32'd1, 0);
    send_sample(7, 32'd1, 0);
    idle(15);
    checks++; if (cap_data_q.size() != 0) begin errors++; $display("FAIL seq_no_output got=%0d exp=0", cap_data_q.size()); end
    in_frames = 8'd0;
    for (int i = 0; i < 8; i++) send_sample(i, 32'(7 + i), 0);
    wait_words(8, 1'b0, 30, "seq_recover");
    for (int i = 0; i < 8; i++) begin
      checks++; if (cap_data_q[i] !== 40'(7 + i)) begin errors++; $display("FAIL seq_data[%0d] got=%0d exp=%0d", i, cap_data_q[i], 7 + i); end
    end
    idle(4);
    send_sample(0, 32'd1, 0);
    send_sample(1, 32'd1, 0);
    for (int i = 0; i < 8; i++) send_sample(i, 32'd20, 0);
    wait_words(16, 1'b0, 30, "seq_resync");
    checks++; if (n_seq != 2) begin errors++; $display("FAIL seq_resync_pulse got=%0d exp=2", n_seq); end
    for (int i = 8; i < 16; i++) begin
      checks++; if (cap_data_q[i] !== 40'd20) begin errors++; $display("FAIL seq_resync_data[%0d] got=%0d exp=20", i, cap_data_q[i]); end
    end
    idle(4);
  endtask

  task automatic test_overrun();
    clear_all();
    out_ready = 1'b0;
    in_frames = 8'd1;
    for (int i = 0; i < 8; i++) send_sample(i, 32'(i + 1), 0);
    idle(3);
    for (int i = 0; i < 8; i++) send_sample(i, 32'd50, 0);
    idle(3);
    checks++; if (n_ovr != 1) begin errors++; $display("FAIL overrun_pulse got=%0d exp=1", n_ovr); end
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      checks++;
      if (m_valid !== 1'b1 || m_index !== 3'd0 || m_data !== 40'd1 || m_last !== 1'b0) begin
        errors++; $display("FAIL overrun_hold got v=%0d i=%0d d=%0d l=%0d exp v=1 i=0 d=1 l=0", m_valid, m_index, m_data, m_last);
      end
    end
    @(posedge Clk); #1;
    out_ready = 1'b1;
    wait_words(8, 1'b0, 30, "overrun_dump");
    idle(12);
    checks++; if (cap_data_q.size() != 8) begin errors++; $display("FAIL overrun_count got=%0d exp=8", cap_data_q.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (cap_data_q[i] !== 40'(i + 1) || cap_idx_q[i] !== 3'(i)) begin errors++; $display("FAIL overrun_data[%0d] got=%0d@%0d exp=%0d", i, cap_data_q[i], cap_idx_q[i], i + 1); end
    end
    for (int i = 0; i < 8; i++) send_sample(i, 32'd3, 0);
    wait_words(16, 1'b0, 30, "overrun_next");
    for (int i = 8; i < 16; i++) begin
      checks++; if (cap_data_q[i] !== 40'd3) begin errors++; $display("FAIL overrun_next_data[%0d] got=%0d exp=3", i, cap_data_q[i]); end
    end
    idle(4);
  endtask

  task automatic test_reset_mid_dump();
    clear_all();
    out_ready = 1'b0;
    in_frames = 8'd1;
    for (int i = 0; i < 8; i++) send_sample(i, 32'(2 * i + 1), 0);
    idle(3);
    out_ready = 1'b1;
    idle(3);
    Rst_n = 1'b0;
    idle(1);
    Rst_n = 1'b1;
    @(negedge Clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rstdump_valid got=%0d exp=0", m_valid); end
    checks++; if (cap_data_q.size() != 3) begin errors++; $display("FAIL rstdump_count got=%0d exp=3", cap_data_q.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (cap_data_q[i] !== 40'(2 * i + 1)) begin errors++; $display("FAIL rstdump_pre[%0d] got=%0d exp=%0d", i, cap_data_q[i], 2 * i + 1); end
    end
    @(posedge Clk); #1;
    idle(2);
    for (int i = 0; i < 8; i++) send_sample(i, 32'd11, 0);
    wait_words(11, 1'b0, 30, "rstdump_next");
    for (int i = 3; i < 11; i++) begin
      checks++; if (cap_idx_q[i] !== 3'(i - 3) || cap_data_q[i] !== 40'd11) begin errors++; $display("FAIL rstdump_next[%0d] got=%0d@%0d exp=11@%0d", i, cap_data_q[i], cap_idx_q[i], i - 3); end
    end
    idle(4);
  endtask

  task automatic test_back_to_back();
    clear_all();
    out_ready = 1'b1;
    in_frames = 8'd1;
    for (int i = 0; i < 8; i++) send_sample(i, 32'(100 + i), 0);
    idle(4);
    for (int i = 0; i < 8; i++) send_sample(i, 32'(200 + i), 0);
    for (int i = 0; i < 8; i++) exp_q.push_back(40'(100 + i));
    for (int i = 0; i < 8; i++) exp_q.push_back(40'(200 + i));
    wait_words(16, 1'b0, 40, "b2b");
    for (int i = 0; i < 16; i++) begin
      checks++; if (cap_data_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_data[%0d] got=%0d exp=%0d", i, cap_data_q[i], exp_q[i]); end
    end
    checks++; if (n_ovr != 0) begin errors++; $display("FAIL b2b_overrun got=%0d exp=0", n_ovr); end
    idle(4);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pattern();
    test_overflow();
    test_sequence();
    test_overrun();
    test_reset_mid_dump();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
